// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage LoongArch pipeline.
// Owns the PC and the pre-IF next-PC mux, and issues requests to the
// synchronous-read instruction SRAM. It holds the fetched word across
// decode stalls and takes branch redirects from ID.
// Optional build macro IF_ADEF_EN: when defined, a misaligned fetch
// address suppresses the SRAM request. The instruction is then delivered
// with excp_adef=1 and inst=0.
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          FS_TO_DS_BUS_WD = 65,
  parameter int          BR_BUS_WD       = 33
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  logic        br_taken;
  logic [31:0] br_target;
  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;
  logic        excp_adef;
  logic        req_ok;

  logic        fs_valid_q,         fs_valid_d;
  logic [31:0] fs_pc_q,            fs_pc_d;
  logic [31:0] inst_buf_q,         inst_buf_d;
  logic        inst_buf_valid_q,   inst_buf_valid_d;
  logic        br_pend_q,          br_pend_d;
  logic [31:0] br_pend_target_q,   br_pend_target_d;
  logic        fs_cancel_q,        fs_cancel_d;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  // Pre-IF: choose the next fetch address.
  // A live redirect wins over one parked during a stall.
  assign to_fs_valid = ~reset;
  assign seq_pc      = fs_pc_q + 32'd4;
  assign nextpc      = br_taken  ? br_target :
                       br_pend_q ? br_pend_target_q : seq_pc;

  assign fs_ready_go = 1'b1;
  assign fs_allowin  = ~fs_valid_q | (fs_ready_go & ds_allowin);

`ifdef IF_ADEF_EN
  logic excp_adef_q, excp_adef_d;
  logic nextpc_misalign;

  assign nextpc_misalign = (nextpc[1:0] != 2'b00);
  assign req_ok          = ~nextpc_misalign;
  assign excp_adef       = excp_adef_q;

  // The address-error flag travels with fs_pc.
  always_comb begin
    excp_adef_d = excp_adef_q;
    if (fs_allowin) excp_adef_d = nextpc_misalign;
  end

  // Address-error flag register.
  always_ff @(posedge clk) begin
    if (reset) excp_adef_q <= 1'b0;
    else       excp_adef_q <= excp_adef_d;
  end
`else
  assign req_ok    = 1'b1;
  assign excp_adef = 1'b0;
`endif

  assign inst_sram_en    = to_fs_valid & fs_allowin & req_ok;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_wdata = 32'h0;

  // Once a stall starts, the buffered word replaces the live SRAM output,
  // which may change after the request drops.
  assign fs_inst = excp_adef        ? 32'h0      :
                   inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;

  // Gate on reset so nothing leaks downstream while reset is applied.
  assign fs_to_ds_valid = fs_valid_q & fs_ready_go & ~br_taken & ~fs_cancel_q & ~reset;
  assign fs_to_ds_bus   = {excp_adef, fs_inst, fs_pc_q};

  // Next-state logic. Either advance the stage, or hold it while recording
  // a redirect and capturing the fetched word for the rest of the stall.
  always_comb begin
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    inst_buf_d       = inst_buf_q;
    inst_buf_valid_d = inst_buf_valid_q;
    br_pend_d        = br_pend_q;
    br_pend_target_d = br_pend_target_q;
    fs_cancel_d      = fs_cancel_q;
    if (fs_allowin) begin
      fs_valid_d       = to_fs_valid;
      fs_pc_d          = nextpc;
      inst_buf_valid_d = 1'b0;
      br_pend_d        = 1'b0;
      fs_cancel_d      = 1'b0;
    end else begin
      if (br_taken) begin
        br_pend_d        = 1'b1;
        br_pend_target_d = br_target;
        fs_cancel_d      = 1'b1;
      end
      if (fs_valid_q && !inst_buf_valid_q) begin
        inst_buf_d       = inst_sram_rdata;
        inst_buf_valid_d = 1'b1;
      end
    end
  end

  // Stage state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      inst_buf_q       <= 32'h0;
      inst_buf_valid_q <= 1'b0;
      br_pend_q        <= 1'b0;
      br_pend_target_q <= 32'h0;
      fs_cancel_q      <= 1'b0;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      inst_buf_q       <= inst_buf_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      br_pend_q        <= br_pend_d;
      br_pend_target_q <= br_pend_target_d;
      fs_cancel_q      <= fs_cancel_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small synchronous-read SRAM model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        corrupt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ds_allowin     (ds_allowin),
    .br_bus         ({br_taken, br_target}),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5a5a0f0f;
  endfunction

  // SRAM: one-cycle read latency; output may be trashed when not requested.
  always @(posedge clk) begin
    if (inst_sram_en)  inst_sram_rdata <= inst_of(inst_sram_addr);
    else if (corrupt)  inst_sram_rdata <= 32'hdeadbeef;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        da;
    logic        br;
    logic [31:0] tgt;
    logic        cor;
    logic        ev;
    logic        een;
    logic [31:0] eaddr;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic rst, input logic da, input logic br,
                              input logic [31:0] tgt, input logic cor, input logic ev,
                              input logic een, input logic [31:0] eaddr, input logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.da = da; v.br = br; v.tgt = tgt; v.cor = cor;
    v.ev = ev; v.een = een; v.eaddr = eaddr; v.epc = epc;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset      = v.rst;
    ds_allowin = v.da;
    br_taken   = v.br;
    br_target  = v.tgt;
    corrupt    = v.cor;
    #3;
    check($sformatf("valid[%0d]", idx), {31'h0, fs_to_ds_valid}, {31'h0, v.ev});
    check($sformatf("en[%0d]", idx),    {31'h0, inst_sram_en},   {31'h0, v.een});
    check($sformatf("addr[%0d]", idx),  inst_sram_addr,          v.eaddr);
    if (v.ev) begin
      check($sformatf("pc[%0d]", idx),   fs_to_ds_bus[31:0],  v.epc);
      check($sformatf("inst[%0d]", idx), fs_to_ds_bus[63:32], inst_of(v.epc));
      check($sformatf("adef[%0d]", idx), {31'h0, fs_to_ds_bus[64]}, 32'h0);
    end
  endtask

  initial begin
    //               rst da br tgt           cor ev en  addr          pc
    vecs[0]  = mk(1, 1, 0, 32'h0,        0, 0, 0, 32'h1c000000, 32'h0);
    vecs[1]  = mk(0, 1, 0, 32'h0,        0, 0, 1, 32'h1c000000, 32'h0);
    vecs[2]  = mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h1c000004, 32'h1c000000);
    vecs[3]  = mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h1c000008, 32'h1c000004);
    vecs[4]  = mk(0, 0, 0, 32'h0,        1, 1, 0, 32'h1c00000c, 32'h1c000008);
    vecs[5]  = mk(0, 0, 0, 32'h0,        1, 1, 0, 32'h1c00000c, 32'h1c000008);
    vecs[6]  = mk(0, 0, 0, 32'h0,        1, 1, 0, 32'h1c00000c, 32'h1c000008);
    vecs[7]  = mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h1c00000c, 32'h1c000008);
    vecs[8]  = mk(0, 1, 1, 32'h1c000100, 0, 0, 1, 32'h1c000100, 32'h0);
    vecs[9]  = mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h1c000104, 32'h1c000100);
    vecs[10] = mk(0, 0, 1, 32'h1c000200, 0, 0, 0, 32'h1c000200, 32'h0);
    vecs[11] = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h1c000200, 32'h0);
    vecs[12] = mk(0, 1, 0, 32'h0,        0, 0, 1, 32'h1c000200, 32'h0);
    vecs[13] = mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h1c000204, 32'h1c000200);
    vecs[14] = mk(0, 0, 1, 32'h1c000300, 0, 0, 0, 32'h1c000300, 32'h0);
    vecs[15] = mk(0, 0, 1, 32'h1c000400, 0, 0, 0, 32'h1c000400, 32'h0);
    vecs[16] = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h1c000400, 32'h0);
    vecs[17] = mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h1c000400, 32'h0);
    vecs[18] = mk(0, 1, 0, 32'h0,        0, 0, 1, 32'h1c000000, 32'h0);
    vecs[19] = mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h1c000004, 32'h1c000000);
    vecs[20] = mk(0, 1, 1, 32'hfffffffc, 0, 0, 1, 32'hfffffffc, 32'h0);
    vecs[21] = mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h00000000, 32'hfffffffc);

    reset = 1'b1; ds_allowin = 1'b1; br_taken = 1'b0; br_target = 32'h0; corrupt = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 22; i++) apply(vecs[i], i);

    // Redirect to a misaligned target.
    @(negedge clk);
    ds_allowin = 1'b1; br_taken = 1'b1; br_target = 32'h1c000102;
    #3;
    check("mis_addr", inst_sram_addr, 32'h1c000102);
    check("mis_valid", {31'h0, fs_to_ds_valid}, 32'h0);
`ifdef IF_ADEF_EN
    check("mis_en", {31'h0, inst_sram_en}, 32'h0);
`else
    check("mis_en", {31'h0, inst_sram_en}, 32'h1);
`endif
    @(negedge clk);
    br_taken = 1'b0; br_target = 32'h0;
    #3;
    check("mis_dvalid", {31'h0, fs_to_ds_valid}, 32'h1);
    check("mis_pc", fs_to_ds_bus[31:0], 32'h1c000102);
    check("mis_addr2", inst_sram_addr, 32'h1c000106);
`ifdef IF_ADEF_EN
    check("mis_adef", {31'h0, fs_to_ds_bus[64]}, 32'h1);
    check("mis_inst", fs_to_ds_bus[63:32], 32'h0);
    check("mis_en2", {31'h0, inst_sram_en}, 32'h0);
`else
    check("mis_adef", {31'h0, fs_to_ds_bus[64]}, 32'h0);
    check("mis_inst", fs_to_ds_bus[63:32], inst_of(32'h1c000102));
    check("mis_en2", {31'h0, inst_sram_en}, 32'h1);
`endif
    check("we_const", {28'h0, inst_sram_we}, 32'h0);
    check("wdata_const", inst_sram_wdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
